// File: rtl/arb_mux_rr.sv
// arb_mux_rr: N:1 round-robin / fixed-select mux feeding a
// single-entry registered output stage with valid/ready handshake.
module arb_mux_rr #(
    parameter int DATAWIDTH = 32,
    parameter int NUM_IN    = 6,
    parameter int SEL_W     = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_IN-1:0]           in_valid_i,
    input  logic [NUM_IN*DATAWIDTH-1:0] in_data_i,
    output logic [NUM_IN-1:0]           in_ready_o,
    input  logic                        mode_i,
    input  logic [SEL_W-1:0]            sel_i,
    output logic                        out_valid_o,
    output logic [DATAWIDTH-1:0]        out_data_o,
    output logic [SEL_W-1:0]            out_src_o,
    input  logic                        out_ready_i
);

    logic [SEL_W-1:0]     rr_ptr;
    logic [NUM_IN-1:0]    grant;
    logic [SEL_W-1:0]     gidx;
    logic [SEL_W-1:0]     idx;
    logic                 found;
    logic                 space;
    logic                 xfer;
    logic [DATAWIDTH-1:0] gdata;
    int                   pos;

    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        if (mode_i) begin
            if (int'(sel_i) < NUM_IN) begin
                if (in_valid_i[sel_i]) begin
                    found = 1'b1;
                    gidx  = sel_i;
                end
            end
        end else begin
            // walk channels starting at rr_ptr, wrapping at NUM_IN
            for (int i = 0; i < NUM_IN; i++) begin
                pos = int'(rr_ptr) + i;
                if (pos >= NUM_IN) pos = pos - NUM_IN;
                idx = SEL_W'(pos);
                if (!found && in_valid_i[idx]) begin
                    found = 1'b1;
                    gidx  = idx;
                end
            end
        end
        if (found) grant[gidx] = 1'b1;
    end

    always_comb begin
        gdata = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (grant[k]) gdata = gdata | in_data_i[k*DATAWIDTH +: DATAWIDTH];
        end
    end

    // reset gates ready so nothing is accepted while held in reset
    assign space      = ~out_valid_o | out_ready_i;
    assign in_ready_o = grant & {NUM_IN{space & rst_ni}};
    assign xfer       = found & space & rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_src_o   <= '0;
            rr_ptr      <= '0;
        end else if (xfer) begin
            out_valid_o <= 1'b1;
            out_data_o  <= gdata;
            out_src_o   <= gidx;
            if (!mode_i) begin
                rr_ptr <= (gidx == SEL_W'(NUM_IN - 1)) ? '0 : gidx + 1'b1;
            end
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux_rr.sv
// tb_arb_mux_rr: directed vector table, hand-written corner
// sequences and a randomized scoreboard run for arb_mux_rr.
module tb_arb_mux_rr;

    localparam int DW = 32;
    localparam int N  = 6;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    in_valid = '0;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0]    in_ready;
    logic            mode = 1'b0;
    logic [SW-1:0]   sel = '0;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic            out_ready = 1'b0;

    int total = 0;
    int passed = 0;

    arb_mux_rr #(.DATAWIDTH(DW), .NUM_IN(N), .SEL_W(SW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .mode_i     (mode),
        .sel_i      (sel),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
        .out_src_o  (out_src),
        .out_ready_i(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         m;
        logic [2:0]   s;
        logic [5:0]   v;
        logic         r;
        logic [5:0]   ir;
        logic         ov;
        logic [2:0]   src;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] dval(input int k);
        return 32'hC0DE_0000 + 32'(k) * 32'h0101;
    endfunction

    function automatic vec_t mk(input logic m, input logic [2:0] s,
                                input logic [5:0] v, input logic r,
                                input logic [5:0] ir, input logic ov,
                                input logic [2:0] src);
        vec_t t;
        t.m = m; t.s = s; t.v = v; t.r = r;
        t.ir = ir; t.ov = ov; t.src = src;
        return t;
    endfunction

    task automatic drive(input logic m, input logic [2:0] s,
                         input logic [5:0] v, input logic r);
        @(negedge clk);
        mode = m; sel = s; in_valid = v; out_ready = r;
        #1;
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0]  pend;
    logic [N-1:0]  acc;
    logic [31:0]   q[$];
    logic [31:0]   front;
    int            wt[N];
    int            maxw;
    int            seq;

    initial begin
        for (int k = 0; k < N; k++) in_data[k*DW +: DW] = dval(k);

        // reset state, with inputs active
        in_valid = 6'b111111;
        out_ready = 1'b1;
        #2;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        chk("rst_ir", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = '0;
        rst_n = 1'b1;

        // round-robin sweep, wrap, ptr hold in mode 1, fixed select
        tbl.push_back(mk(0, 0, 6'h3F, 1, 6'h01, 1, 0));
        tbl.push_back(mk(0, 0, 6'h3F, 1, 6'h02, 1, 1));
        tbl.push_back(mk(0, 0, 6'h3F, 1, 6'h04, 1, 2));
        tbl.push_back(mk(0, 0, 6'h3F, 1, 6'h08, 1, 3));
        tbl.push_back(mk(0, 0, 6'h3F, 1, 6'h10, 1, 4));
        tbl.push_back(mk(0, 0, 6'h3F, 1, 6'h20, 1, 5));
        tbl.push_back(mk(0, 0, 6'h3F, 1, 6'h01, 1, 0));
        tbl.push_back(mk(0, 0, 6'h08, 1, 6'h08, 1, 3));
        tbl.push_back(mk(0, 0, 6'h05, 1, 6'h01, 1, 0));
        tbl.push_back(mk(0, 0, 6'h05, 1, 6'h04, 1, 2));
        tbl.push_back(mk(0, 0, 6'h02, 1, 6'h02, 1, 1));
        tbl.push_back(mk(0, 0, 6'h00, 1, 6'h00, 0, 0));
        tbl.push_back(mk(1, 1, 6'h04, 1, 6'h00, 0, 0));
        tbl.push_back(mk(1, 2, 6'h3F, 1, 6'h04, 1, 2));
        tbl.push_back(mk(1, 2, 6'h3F, 1, 6'h04, 1, 2));
        tbl.push_back(mk(1, 7, 6'h3F, 1, 6'h00, 0, 0));
        tbl.push_back(mk(1, 7, 6'h3F, 1, 6'h00, 0, 0));
        tbl.push_back(mk(0, 0, 6'h3F, 1, 6'h04, 1, 2));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].r);
            chk($sformatf("v%0d_ir", i), 32'(in_ready), 32'(tbl[i].ir));
            post();
            chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk($sformatf("v%0d_src", i), 32'(out_src), 32'(tbl[i].src));
                chk($sformatf("v%0d_data", i), out_data, dval(int'(tbl[i].src)));
            end
        end

        // backpressure: ch3 beat held while downstream stalls
        in_data[3*DW +: DW] = 32'hDEAD_BEEF;
        drive(0, 0, 6'h08, 1);
        chk("hold_load_ir", 32'(in_ready), 32'h08);
        post();
        chk("hold_load_data", out_data, 32'hDEAD_BEEF);
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 6'h3F, 0);
            chk($sformatf("stall%0d_ir", c), 32'(in_ready), 32'd0);
            post();
            chk($sformatf("stall%0d_ov", c), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_src", c), 32'(out_src), 32'd3);
            chk($sformatf("stall%0d_data", c), out_data, 32'hDEAD_BEEF);
        end
        in_data[3*DW +: DW] = dval(3);
        // release: pop old beat and load ch4 in the same cycle
        drive(0, 0, 6'h3F, 1);
        chk("rel_ir", 32'(in_ready), 32'h10);
        post();
        chk("rel_src", 32'(out_src), 32'd4);
        chk("rel_data", out_data, dval(4));
        drive(0, 0, 6'h00, 1);
        post();
        chk("drain_ov", 32'(out_valid), 32'd0);

        // asynchronous reset between edges while holding a beat
        drive(0, 0, 6'h01, 1);
        chk("pre_rst_ir", 32'(in_ready), 32'h01);
        post();
        chk("pre_rst_ov", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", 32'(out_valid), 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_src", 32'(out_src), 32'd0);
        drive(0, 0, 6'h3F, 1);
        chk("in_rst_ir", 32'(in_ready), 32'd0);
        post();
        chk("in_rst_ov", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 6'b100001;
        #1;
        chk("post_rst_ir", 32'(in_ready), 32'h01);
        post();
        chk("post_rst_src", 32'(out_src), 32'd0);
        drive(0, 0, 6'h00, 1);
        post();

        // randomized scoreboard run, sources hold valid until accepted
        pend = '0;
        seq = 0;
        maxw = 0;
        for (int k = 0; k < N; k++) wt[k] = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(1, 0) == 1) begin
                    pend[k] = 1'b1;
                    seq++;
                    in_data[k*DW +: DW] = {4'(k), 28'(seq)};
                end
            end
            mode = 1'b0;
            in_valid = pend;
            out_ready = ($urandom_range(3, 0) != 0);
            #1;
            chk("onehot", 32'($onehot0(in_ready)), 32'd1);
            acc = in_valid & in_ready;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("dup_beat", out_data, 32'hFFFF_FFFF);
                end else begin
                    front = q.pop_front();
                    chk("beat", out_data, front);
                end
            end
            if (acc != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (acc[k]) begin
                        q.push_back(in_data[k*DW +: DW]);
                        wt[k] = 0;
                    end else if (pend[k]) begin
                        wt[k]++;
                        if (wt[k] > maxw) maxw = wt[k];
                    end
                end
            end
            @(posedge clk);
            pend = pend & ~acc;
        end
        @(negedge clk);
        in_valid = '0;
        out_ready = 1'b1;
        #1;
        if (out_valid) begin
            if (q.size() == 0) chk("dup_tail", out_data, 32'hFFFF_FFFF);
            else begin
                front = q.pop_front();
                chk("beat_tail", out_data, front);
            end
        end
        post();
        chk("lost_beats", 32'(q.size()), 32'd0);
        chk("final_ov", 32'(out_valid), 32'd0);
        chk("fairness", 32'(maxw <= N - 1), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/arb_mux_rr.md
ARB_MUX_RR -- requirements
Module: arb_mux_rr

Interface
REQ-001: Parameter DATAWIDTH, default 32, width of each data channel.
REQ-002: Parameter NUM_IN, default 6, number of input channels; legal range 2..16.
REQ-003: Parameter SEL_W, default 3, select/index width; SHALL equal ceil(log2(NUM_IN)).
REQ-004: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005: rst_ni  input  1  asynchronous, active-low reset.
REQ-006: in_valid_i  input  NUM_IN  per-channel valid; bit k belongs to channel k.
REQ-007: in_data_i  input  NUM_IN*DATAWIDTH  packed channel data; channel k occupies bits [k*DATAWIDTH +: DATAWIDTH].
REQ-008: in_ready_o  output  NUM_IN  per-channel ready; at most one bit set in any cycle.
REQ-009: mode_i  input  1  0 = round-robin arbitration, 1 = fixed select.
REQ-010: sel_i  input  SEL_W  channel index used when mode_i = 1.
REQ-011: out_valid_o  output  1  output register holds a valid beat.
REQ-012: out_data_o  output  DATAWIDTH  registered selected data.
REQ-013: out_src_o  output  SEL_W  index of the channel that supplied out_data_o.
REQ-014: out_ready_i  input  1  downstream accepts the beat when out_valid_o & out_ready_i.

Function
REQ-015: Internal rr_ptr (SEL_W bits) SHALL name the highest-priority channel for round-robin.
REQ-016: mode_i = 0: grant SHALL go to the first k with in_valid_i[k] = 1, searching rr_ptr, rr_ptr+1, ..., wrapping NUM_IN-1 -> 0.
REQ-017: mode_i = 1: grant SHALL go to channel sel_i iff in_valid_i[sel_i] = 1; if sel_i >= NUM_IN, no grant.
REQ-018: Grant, in_ready_o and the mode/sel decode SHALL be combinational; changes to mode_i/sel_i take effect in the same cycle.
REQ-019: space = ~out_valid_o | out_ready_i; in_ready_o[k] SHALL equal grant[k] & space.
REQ-020: Transfer on channel k occurs when in_valid_i[k] & in_ready_o[k]; on that edge out_data_o <= channel k data, out_src_o <= k, out_valid_o <= 1.
REQ-021: Latency input-accept to out_valid_o SHALL be exactly 1 cycle; sustained throughput 1 beat/cycle when out_ready_i = 1.
REQ-022: If out_valid_o & out_ready_i and no transfer occurs, out_valid_o SHALL go 0 on the next edge.
REQ-023: If out_valid_o & ~out_ready_i, out_data_o and out_src_o SHALL hold stable and all in_ready_o SHALL be 0.
REQ-024: On a transfer in mode 0, rr_ptr SHALL become k+1, wrapping NUM_IN-1 -> 0.
REQ-025: In mode 1, or with no transfer, rr_ptr SHALL hold.
REQ-026: No valid inputs: no grant, output register drains per REQ-022, rr_ptr holds.
REQ-027: Simultaneous downstream pop and upstream transfer in one cycle SHALL be lossless (pop old beat, load new beat).
REQ-028: out_data_o SHALL be registered only; no combinational path from in_data_i to out_data_o.
REQ-029: in_valid_i on a non-granted channel SHALL NOT alter any state.

Reset
REQ-030: While rst_ni = 0: out_valid_o = 0, out_data_o = 0, out_src_o = 0, rr_ptr = 0, immediately (asynchronous).
REQ-031: Reset asserted mid-transfer SHALL discard the held beat; no in_ready_o is asserted while rst_ni = 0.
REQ-032: First grant after rst_ni deasserts SHALL follow REQ-016 from rr_ptr = 0.

Verification
REQ-033: Reset, mode 0, in_valid_i = 6'b111111, out_ready_i = 1 for 7 cycles -> out_src_o sequence 0,1,2,3,4,5,0, out_valid_o high from cycle 2.
REQ-034: Mode 0, rr_ptr = 4, in_valid_i = 6'b000101 -> grant ch0 (wrap past 4,5), next rr_ptr = 1, then ch2 granted next cycle.
REQ-035: Beat ch3 = 32'hDEAD_BEEF held, out_ready_i = 0 for 3 cycles -> out_data_o stable at 32'hDEAD_BEEF, in_ready_o = 0 throughout, released on out_ready_i = 1.
REQ-036: Mode 1, sel_i = 2, in_valid_i = 6'b111111 -> only ch2 transfers each cycle, rr_ptr unchanged; sel_i = 7 -> no grant, out_valid_o drains to 0.
REQ-037: rst_ni pulled low asynchronously between edges with out_valid_o = 1 -> out_valid_o = 0 and out_data_o = 0 before next clock edge.
REQ-038: Random valid/ready with scoreboard over 10k cycles -> no beat lost or duplicated, in_ready_o one-hot-or-zero always, each continuously valid channel granted within NUM_IN transfers.
